dac_spi_tx: RTL and testbench

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_tx_pkg.sv | 12 +
 rtl/dac_spi_tx_spi_clk_gen.sv | 18 +
 rtl/dac_spi_tx.sv | 99 +++++++++
 tb/tb_dac_spi_tx.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg: shared states, frame constants and frame builder for the DAC SPI transmitter.
package dac_spi_tx_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;
  localparam int FRAME_W = 16;
  localparam int CNT_W = 8;
  localparam logic [3:0] DAC_CFG = 4'b0011;
  localparam logic [9:0] DAC_OFFSET = 10'h200;
  // Channel A, unbuffered, gain 1x, active; 10-bit sample left-justified in 12 bits.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [9:0] d);
    return {DAC_CFG, d, 2'b00};
  endfunction
endpackage

// File: rtl/dac_spi_tx_spi_clk_gen.sv
// spi_clk_gen: emits a one-cycle tick every CLK_DIV sysclk cycles while enabled.
module spi_clk_gen
  import dac_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  always_comb cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge sysclk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: 16-bit SPI frame transmitter for a 10-bit DAC with optional LDAC pulse.
// Define DAC_LDAC_PULSE_EN to generate the latch pulse; otherwise dac_ld_n is tied low.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       overrun,
  output logic       dac_cs_n,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ld_n
);
  state_e             state_q;
  logic [3:0]         bit_q;
  logic [FRAME_W-1:0] sh_q;
  logic               busy_q, ovr_q, cs_q, sck_q, sdi_q, tick;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

`ifdef DAC_LDAC_PULSE_EN
  logic ld_q;
  assign dac_ld_n = ld_q;
`else
  assign dac_ld_n = 1'b0;
`endif

  assign busy     = busy_q;
  assign overrun  = ovr_q;
  assign dac_cs_n = cs_q;
  assign dac_sck  = sck_q;
  assign dac_sdi  = sdi_q;

  // Each tick ends one SCK half-period; sdi only moves on the high-to-low tick.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      sdi_q   <= 1'b0;
`ifdef DAC_LDAC_PULSE_EN
      ld_q    <= 1'b1;
`endif
    end else begin
      if (load && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (load) begin
          state_q       <= SHIFT;
          busy_q        <= 1'b1;
          cs_q          <= 1'b0;
          sck_q         <= 1'b0;
          bit_q         <= 4'd15;
          {sdi_q, sh_q} <= {build_frame(data_in), 1'b0};
        end
        SHIFT: if (tick) begin
          if (!sck_q) sck_q <= 1'b1;
          else if (bit_q == 4'd0) begin
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
`ifdef DAC_LDAC_PULSE_EN
            state_q <= LATCH;
            ld_q    <= 1'b0;
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end else begin
            sck_q         <= 1'b0;
            bit_q         <= bit_q - 4'd1;
            {sdi_q, sh_q} <= {sh_q, 1'b0};
          end
        end
`ifdef DAC_LDAC_PULSE_EN
        LATCH: if (tick) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ld_q    <= 1'b1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed self-checking bench for dac_spi_tx at CLK_DIV=2.
module tb_dac_spi_tx;
  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data_in = '0;
  logic       load = 1'b0;
  logic       busy, overrun, dac_cs_n, dac_sck, dac_sdi, dac_ld_n;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] f;
  int          low, ldl, bo, viol, n;
  bit          done;

  dac_spi_tx #(.CLK_DIV(2)) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .load     (load),
    .busy     (busy),
    .overrun  (overrun),
    .dac_cs_n (dac_cs_n),
    .dac_sck  (dac_sck),
    .dac_sdi  (dac_sdi),
    .dac_ld_n (dac_ld_n)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loads d, then samples every falling edge until busy drops (bounded);
  // at step extra_at a second load with different data is attempted.
  task automatic run_frame(input logic [9:0] d, input int extra_at,
                           output logic [15:0] fr, output int lo, output int ll,
                           output int b, output int v, output int ns, output bit ok);
    logic ps, pd;
    fr = '0; lo = 0; ll = 0; b = 0; v = 0; ns = 0; ok = 0; ps = 0; pd = 0;
    data_in = d;
    load = 1'b1;
    @(negedge sysclk);
    for (int i = 0; i < 200; i++) begin
      load = (i == extra_at);
      if (i == extra_at) data_in = ~d;
      ns++;
      if (!dac_cs_n) lo++;
      if (!dac_ld_n) ll++;
      if (busy && dac_cs_n) b++;
      if (dac_sck && !ps) fr = {fr[14:0], dac_sdi};
      if (dac_sck && ps && dac_sdi !== pd) v++;
      ps = dac_sck;
      pd = dac_sdi;
      if (!busy) begin
        ok = 1;
        break;
      end
      @(negedge sysclk);
    end
    load = 1'b0;
  endtask

  task automatic frame_checks(input string tag, input logic [15:0] exp);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_frame"}, 32'(f), 32'(exp));
    check({tag, "_cs_low"}, low, 64);
    check({tag, "_sdi_stable"}, viol, 0);
`ifdef DAC_LDAC_PULSE_EN
    check({tag, "_ld_low"}, ldl, 2);
    check({tag, "_latch_busy"}, bo, 2);
`else
    check({tag, "_ld_const0"}, ldl, n);
    check({tag, "_busy_with_cs"}, bo, 0);
`endif
  endtask

  initial begin
    repeat (3) @(negedge sysclk);
    check("rst_cs_n", 32'(dac_cs_n), 1);
    check("rst_sck", 32'(dac_sck), 0);
    check("rst_sdi", 32'(dac_sdi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(overrun), 0);
`ifdef DAC_LDAC_PULSE_EN
    check("rst_ld_n", 32'(dac_ld_n), 1);
`else
    check("rst_ld_n", 32'(dac_ld_n), 0);
`endif
    rst_n = 1'b1;
    @(negedge sysclk);

    run_frame(10'h200, -1, f, low, ldl, bo, viol, n, done);
    frame_checks("mid", 16'h3800);
    run_frame(10'h3FF, -1, f, low, ldl, bo, viol, n, done);
    frame_checks("max", 16'h3FFC);
    run_frame(10'h000, -1, f, low, ldl, bo, viol, n, done);
    frame_checks("zero", 16'h3000);
    check("b2b_no_ovr", 32'(overrun), 0);

    run_frame(10'h2AA, 10, f, low, ldl, bo, viol, n, done);
    frame_checks("ovr", 16'h3AA8);
    check("ovr_set", 32'(overrun), 1);
    repeat (5) @(negedge sysclk);
    check("ovr_sticky", 32'(overrun), 1);

    data_in = 10'h2AA;
    load = 1'b1;
    @(negedge sysclk);
    load = 1'b0;
    repeat (33) @(negedge sysclk);
    check("abort_in_frame", 32'(dac_cs_n), 0);
    rst_n = 1'b0;
    @(negedge sysclk);
    check("abort_cs_n", 32'(dac_cs_n), 1);
    check("abort_sck", 32'(dac_sck), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sysclk);
    check("abort_stays_idle", 32'(dac_cs_n), 1);

    run_frame(10'h155, -1, f, low, ldl, bo, viol, n, done);
    frame_checks("after_rst", 16'h3554);
    check("after_rst_ovr", 32'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
